// File: rtl/stopwatch_display_ctl_pkg.sv
// Shared definitions for the stopwatch display controller: FSM state
// encoding, active-high 7-segment glyphs, digit indices and BCD stepping.
package stopwatch_display_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Scan position of each digit
    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    // Advance an MM:SS BCD count by one second, wrapping to 00:00 after
    // max_mt max_mo : 59. Digits never leave 0..9, sec tens never exceed 5.
    function automatic logic [15:0] bcd_inc(input logic [15:0] cur,
                                            input logic [3:0]  max_mt,
                                            input logic [3:0]  max_mo);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = cur;
        if (so != 4'd9) begin
            so = so + 4'd1;
        end else begin
            so = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if ((mt == max_mt) && (mo == max_mo)) begin
                    mt = 4'd0;
                    mo = 4'd0;
                end else if (mo != 4'd9) begin
                    mo = mo + 4'd1;
                end else begin
                    mo = 4'd0;
                    mt = mt + 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern; codes 10..15 are blank.
module bcd_to_seg7
    import stopwatch_display_ctl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    // Glyph lookup
    always_comb begin
        pattern = SEG_BLANK;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_display_ctl.sv
// MM:SS stopwatch counting rising edges of the divider's slow output, with a
// start/pause/clear FSM and a registered 4-digit multiplexed 7-seg driver.
// The divided signals are sampled as data on the single system clock.
module stopwatch_display_ctl
    import stopwatch_display_ctl_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DP_DIGIT       = 2,
    parameter int MAX_MIN        = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic [1:0]  scan_sel,
    input  logic        btn_start,
    input  logic        btn_clear,
    output logic [15:0] bcd,
    output logic        running,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);
    localparam logic [1:0] DP_SEL = 2'(DP_DIGIT);

    sw_state_t   state_r, next_state_s;
    logic        tick_q;
    logic        step_s;
    logic        count_en_s;
    logic        clear_s;
    logic [15:0] bcd_r;
    logic        running_r;
    logic [3:0]  digit_s;
    logic [6:0]  pattern_s;
    logic [7:0]  seg_raw_s;
    logic [3:0]  an_raw_s;
    logic [3:0]  an_r;
    logic [7:0]  seg_r;

    assign step_s     = tick_in & ~tick_q;
    assign count_en_s = step_s & (state_r == RUN);

    // Delay the time base by one clock for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM transitions; clear beats start only while paused
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (btn_start) begin
                    next_state_s = PAUSE;
                end else begin
                    next_state_s = RUN;
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    next_state_s = IDLE;
                    clear_s      = 1'b1;
                end else if (btn_start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = PAUSE;
                end
            end
            default: begin
                next_state_s = IDLE;
                clear_s      = 1'b1;
            end
        endcase
    end

    // Count and running flag, updated on the same edge as the state
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r     <= 16'h0000;
            running_r <= 1'b0;
        end else begin
            if (clear_s) begin
                bcd_r <= 16'h0000;
            end else if (count_en_s) begin
                bcd_r <= bcd_inc(bcd_r, MAX_MT, MAX_MO);
            end else begin
                bcd_r <= bcd_r;
            end
            running_r <= (next_state_s == RUN);
        end
    end

    // Pick the digit under the current scan position
    always_comb begin
        digit_s = bcd_r[3:0];
        case (scan_sel)
            DIG_SEC_ONES: digit_s = bcd_r[3:0];
            DIG_SEC_TENS: digit_s = bcd_r[7:4];
            DIG_MIN_ONES: digit_s = bcd_r[11:8];
            DIG_MIN_TENS: digit_s = bcd_r[15:12];
            default:      digit_s = bcd_r[3:0];
        endcase
    end

    bcd_to_seg7 u_seg7 (
        .digit   (digit_s),
        .pattern (pattern_s)
    );

    assign seg_raw_s = {(scan_sel == DP_SEL), pattern_s};
    assign an_raw_s  = 4'b0001 << scan_sel;

    // Registered display drive with output polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            if (SEG_ACTIVE_LOW != 0) begin
                an_r  <= 4'hF;
                seg_r <= 8'hFF;
            end else begin
                an_r  <= 4'h0;
                seg_r <= 8'h00;
            end
        end else begin
            if (SEG_ACTIVE_LOW != 0) begin
                an_r  <= ~an_raw_s;
                seg_r <= ~seg_raw_s;
            end else begin
                an_r  <= an_raw_s;
                seg_r <= seg_raw_s;
            end
        end
    end

    assign bcd     = bcd_r;
    assign running = running_r;
    assign an      = an_r;
    assign seg     = seg_r;

endmodule

// File: tb/tb_stopwatch_display_ctl.sv
// Directed bench for stopwatch_display_ctl with default parameters
// (active-low display, dp on digit 2, wrap after 59:59).
module tb_stopwatch_display_ctl;

    logic        clk;
    logic        rst;
    logic        tick_in;
    logic [1:0]  scan_sel;
    logic        btn_start;
    logic        btn_clear;
    logic [15:0] bcd;
    logic        running;
    logic [3:0]  an;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_display_ctl dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .scan_sel  (scan_sel),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .bcd       (bcd),
        .running   (running),
        .an        (an),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One tick_in rising edge, held high for `hold` cycles, then low for one
    task automatic tick_edge(input int hold);
        tick_in = 1'b1;
        cyc(hold);
        tick_in = 1'b0;
        cyc(1);
    endtask

    task automatic steps(input int n);
        repeat (n) tick_edge(1);
    endtask

    task automatic pulse(input logic s, input logic c);
        btn_start = s;
        btn_clear = c;
        cyc(1);
        btn_start = 1'b0;
        btn_clear = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        tick_in   = 1'b0;
        scan_sel  = 2'd0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        cyc(3);
        check_eq("rst_an",  {28'h0, an},  32'h0000000F);
        check_eq("rst_seg", {24'h0, seg}, 32'h000000FF);
        rst = 1'b0;
        cyc(2);
        check_eq("idle_an",  {28'h0, an},      32'h0000000E);
        check_eq("idle_seg", {24'h0, seg},     32'h000000C0);
        check_eq("idle_bcd", {16'h0, bcd},     32'h00000000);
        check_eq("idle_run", {31'h0, running}, 32'h00000000);

        // Start, then three long-held ticks: one count per edge
        pulse(1'b1, 1'b0);
        check_eq("start_run", {31'h0, running}, 32'h00000001);
        repeat (3) tick_edge(5);
        check_eq("three_bcd", {16'h0, bcd}, 32'h00000003);
        check_eq("three_run", {31'h0, running}, 32'h00000001);

        // Seconds to minutes carry
        steps(56);
        check_eq("s59_bcd", {16'h0, bcd}, 32'h00000059);
        steps(1);
        check_eq("m1_bcd", {16'h0, bcd}, 32'h00000100);
        scan_sel = 2'd2;
        cyc(1);
        check_eq("m1_an2",  {28'h0, an},  32'h0000000B);
        check_eq("m1_seg2", {24'h0, seg}, 32'h00000079);
        scan_sel = 2'd3;
        cyc(1);
        check_eq("m1_an3",  {28'h0, an},  32'h00000007);
        check_eq("m1_seg3", {24'h0, seg}, 32'h000000C0);
        scan_sel = 2'd0;

        // Full-scale wrap 59:59 -> 00:00, still running
        steps(3539);
        check_eq("max_bcd", {16'h0, bcd}, 32'h00005959);
        steps(1);
        check_eq("wrap_bcd", {16'h0, bcd},     32'h00000000);
        check_eq("wrap_run", {31'h0, running}, 32'h00000001);

        // Clear ignored in RUN, pause freezes count, clear from PAUSE
        steps(7);
        check_eq("s7_bcd", {16'h0, bcd}, 32'h00000007);
        pulse(1'b0, 1'b1);
        check_eq("runclr_bcd", {16'h0, bcd},     32'h00000007);
        check_eq("runclr_run", {31'h0, running}, 32'h00000001);
        pulse(1'b1, 1'b0);
        check_eq("pause_run", {31'h0, running}, 32'h00000000);
        repeat (4) tick_edge(2);
        check_eq("pause_bcd", {16'h0, bcd}, 32'h00000007);
        pulse(1'b0, 1'b1);
        check_eq("clr_bcd", {16'h0, bcd},     32'h00000000);
        check_eq("clr_run", {31'h0, running}, 32'h00000000);

        // In IDLE, start+clear together starts
        pulse(1'b1, 1'b1);
        check_eq("idle_sc_run", {31'h0, running}, 32'h00000001);
        steps(3);
        check_eq("s3_bcd", {16'h0, bcd}, 32'h00000003);
        pulse(1'b1, 1'b0);
        // In PAUSE, start+clear together clears
        pulse(1'b1, 1'b1);
        check_eq("pause_sc_run", {31'h0, running}, 32'h00000000);
        check_eq("pause_sc_bcd", {16'h0, bcd},     32'h00000000);

        // Step coincident with IDLE->RUN is not counted
        btn_start = 1'b1;
        tick_in   = 1'b1;
        cyc(1);
        btn_start = 1'b0;
        check_eq("startstep_run", {31'h0, running}, 32'h00000001);
        check_eq("startstep_bcd", {16'h0, bcd},     32'h00000000);
        cyc(2);
        tick_in = 1'b0;
        cyc(1);
        check_eq("held_bcd", {16'h0, bcd}, 32'h00000000);

        // Step coincident with RUN->PAUSE is counted
        btn_start = 1'b1;
        tick_in   = 1'b1;
        cyc(1);
        btn_start = 1'b0;
        check_eq("pausestep_bcd", {16'h0, bcd},     32'h00000001);
        check_eq("pausestep_run", {31'h0, running}, 32'h00000000);
        tick_in = 1'b0;
        cyc(1);

        // Reset mid-count at 12:34
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        steps(754);
        check_eq("t1234_bcd", {16'h0, bcd}, 32'h00001234);
        rst     = 1'b1;
        tick_in = 1'b1;
        btn_start = 1'b1;
        cyc(1);
        btn_start = 1'b0;
        check_eq("mrst_bcd", {16'h0, bcd},     32'h00000000);
        check_eq("mrst_run", {31'h0, running}, 32'h00000000);
        check_eq("mrst_an",  {28'h0, an},      32'h0000000F);
        check_eq("mrst_seg", {24'h0, seg},     32'h000000FF);
        tick_in = 1'b0;
        rst     = 1'b0;
        cyc(1);
        tick_edge(1);
        check_eq("postrst_bcd", {16'h0, bcd},     32'h00000000);
        check_eq("postrst_run", {31'h0, running}, 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
